// File: rtl/writeback_buffer.sv
// -----------------------------------------------------------------------------
// writeback_buffer
//
// Small circular FIFO placed behind the data cache's eviction port. Each
// evicted word (address + data) is captured and drained toward memory under a
// valid/ready handshake. A repeated eviction of an address already held is
// folded into the existing entry. A combinational lookup port lets a cache miss
// pick up dirty data that has not yet reached memory.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   in_en        eviction valid (cache store enable)
//   in_addr      evicted word address [ADDR_W:1]
//   in_data      evicted data
//   in_ready     buffer can take in_en this cycle
//   mem_wen      head entry valid toward memory
//   mem_waddr    head entry address
//   mem_wdata    head entry data
//   mem_wready   memory accepts the head this cycle
//   lk_addr      lookup address
//   lk_hit       lookup address is held in the buffer
//   lk_data      data of the youngest matching entry, 0 on miss
//   count        number of occupied entries
//   overflow     sticky: an eviction was dropped since reset
// -----------------------------------------------------------------------------
module writeback_buffer #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_en,
    input  logic [ADDR_W:1]   in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_wen,
    output logic [ADDR_W:1]   mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_wready,
    input  logic [ADDR_W:1]   lk_addr,
    output logic              lk_hit,
    output logic [DATA_W-1:0] lk_data,
    output logic [PTR_W:0]    count,
    output logic              overflow
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Entry storage and control state
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W:1]   addr_q [DEPTH];
    logic [ADDR_W:1]   addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              overflow_q, overflow_d;

    // Derived per-cycle signals
    logic              xfer_s;
    logic              coal_hit_s;
    logic [PTR_W-1:0]  coal_idx_s;
    logic              lk_hit_s;
    logic [PTR_W-1:0]  lk_idx_s;
    logic              in_ready_s;
    logic              alloc_s;

    assign xfer_s = valid_q[head_q] & mem_wready;

    // Scan entries oldest-to-youngest so the last match found is the youngest.
    // The head is skipped for coalescing while it is leaving this cycle, so a
    // fresh eviction of the same address gets its own slot instead of vanishing.
    always_comb begin
        logic [PTR_W-1:0] idx;
        coal_hit_s = 1'b0;
        coal_idx_s = '0;
        lk_hit_s   = 1'b0;
        lk_idx_s   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if (valid_q[idx] && (addr_q[idx] == in_addr) && !(xfer_s && (k == 0))) begin
                coal_hit_s = 1'b1;
                coal_idx_s = idx;
            end else begin
                coal_hit_s = coal_hit_s;
            end
            if (valid_q[idx] && (addr_q[idx] == lk_addr)) begin
                lk_hit_s = 1'b1;
                lk_idx_s = idx;
            end else begin
                lk_hit_s = lk_hit_s;
            end
        end
    end

    assign in_ready_s = (count_q < FULL_CNT) | xfer_s | coal_hit_s;
    assign alloc_s    = in_en & in_ready_s & ~coal_hit_s;

    // Next-state: drain the head, then coalesce or allocate the eviction.
    // Allocation is applied after the head invalidate so a full-buffer
    // enqueue that lands on the departing head slot keeps its valid bit.
    always_comb begin
        valid_d    = valid_q;
        addr_d     = addr_q;
        data_d     = data_q;
        head_d     = head_q;
        tail_d     = tail_q;
        overflow_d = overflow_q | (in_en & ~in_ready_s);

        if (xfer_s) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_ONE;
        end else begin
            head_d = head_q;
        end

        if (in_en && coal_hit_s) begin
            data_d[coal_idx_s] = in_data;
        end else if (alloc_s) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = in_addr;
            data_d[tail_q]  = in_data;
            tail_d          = tail_q + PTR_ONE;
        end else begin
            tail_d = tail_q;
        end

        if (alloc_s && !xfer_s) begin
            count_d = count_q + CNT_ONE;
        end else if (!alloc_s && xfer_s) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // State register with synchronous reset; reset drops every entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign mem_wen   = valid_q[head_q];
    assign mem_waddr = addr_q[head_q];
    assign mem_wdata = data_q[head_q];
    assign lk_hit    = lk_hit_s;
    assign lk_data   = lk_hit_s ? data_q[lk_idx_s] : {DATA_W{1'b0}};
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/writeback_buffer.md
Name: writeback_buffer

Overview:
- Sits directly downstream of the direct-mapped data cache's eviction port.
- Captures each evicted word (address and data) into a small FIFO and drains it to the memory write port under a valid/ready handshake.
- Coalesces repeated evictions of the same address into one entry.
- Offers a combinational lookup so a cache miss can read in-flight dirty data before it reaches memory.

Parameters:
- DEPTH, 4, number of buffer entries (power of two, at least 2).
- PTR_W, 2, log2(DEPTH).
- ADDR_W, 15, word-address width; addresses are carried as [15:1].
- DATA_W, 16, data word width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_en  input  1  eviction valid, driven by the cache's store enable.
- in_addr  input  15 ([15:1])  evicted word address.
- in_data  input  16  evicted data.
- in_ready  output  1  buffer can accept in_en this cycle.
- mem_wen  output  1  head entry valid toward memory.
- mem_waddr  output  15 ([15:1])  head entry address.
- mem_wdata  output  16  head entry data.
- mem_wready  input  1  memory accepts the head this cycle.
- lk_addr  input  15 ([15:1])  lookup address.
- lk_hit  output  1  lookup address is held in the buffer.
- lk_data  output  16  data of the matching entry; 0 when there is no hit.
- count  output  PTR_W+1  number of occupied entries.
- overflow  output  1  sticky flag: an eviction was dropped.

Behaviour:
- Reset: a clock edge with rst_n=0 does the following.
  - Clears all entry valid bits, head and tail pointers, count and overflow.
  - mem_wen=0, in_ready=1, lk_hit=0, lk_data=0, count=0, overflow=0.
  - Reset mid-drain discards every entry, including an un-acked head.
- Storage: DEPTH entries of {valid, addr, data} in a circular FIFO. The head pointer selects the oldest entry; the tail pointer selects the next free slot. Both wrap from DEPTH-1 to 0.
- Drain: the memory write side is a pure function of the head register.
  - mem_wen = head valid; mem_waddr and mem_wdata come from the head entry.
  - A transfer occurs on an edge where mem_wen=1 and mem_wready=1. The head is invalidated and the head pointer advances.
  - mem_waddr and mem_wdata hold stable while mem_wen=1 and mem_wready=0.
- Latency: an eviction accepted at edge N appears at mem_wen from cycle N+1 (if the buffer was empty). Zero-bubble back-to-back drains are required.
- Acceptance: in_ready = (count < DEPTH) or (a transfer occurs this cycle), or in_addr coalesces into an existing entry.
- Coalescing: when in_en=1 and in_addr equals the address of a valid entry, that entry's data is overwritten in place. No slot is allocated and count is unchanged. Exception: if the matching entry is the head being transferred this cycle, the eviction allocates a new tail entry instead, so the new data is not lost.
- Allocation: a non-coalesced accepted eviction writes the tail entry and advances the tail pointer.
- Simultaneous enqueue and transfer: count is unchanged. When full, this case is accepted.
- Drop: in_en=1 with in_ready=0 discards the eviction and sets overflow=1 from the next cycle until reset. The cache has no backpressure, so overflow is a verification error flag.
- Count: +1 on allocate, -1 on transfer, net 0 on both; never exceeds DEPTH and never underflows.
- Lookup: combinational over the registered entries.
  - Same-cycle in_en is not visible.
  - If several valid entries match (only possible transiently after the head exception), the youngest wins.
  - lk_data=0 when lk_hit=0.
- No X on outputs after reset. Address compares use full 15-bit equality.

Test Plan:
- Reset then idle: assert rst_n=0 for 2 cycles and hold mem_wready=0. Expect count=0, mem_wen=0, in_ready=1, lk_hit=0, overflow=0.
- Single eviction: in_en with addr 0x1204, data 0xBEEF at edge 0, mem_wready=0. Expect from cycle 1: mem_wen=1, mem_waddr=0x1204, mem_wdata=0xBEEF, count=1, and lk_addr=0x1204 giving lk_hit=1, lk_data=0xBEEF. Raise mem_wready for one cycle; then expect mem_wen=0 and count=0.
- Fill and wrap: 4 evictions to addrs 0x10, 0x20, 0x30, 0x40 with mem_wready=0, giving count=4 and in_ready=0. Then:
  - Drive in_en for addr 0x50 together with mem_wready=1. Expect it accepted, count=4, mem_waddr=0x20 next cycle, and the tail pointer wrapped.
  - Drain the rest; memory must see 0x10, 0x20, 0x30, 0x40, 0x50 in that order.
- Coalesce: evict 0x30/0x1111, then 0x30/0x2222 with mem_wready=0. Expect count=1, lk_data=0x2222, and a single memory write of 0x2222.
- Head exception: head is 0x30/0x1111 being transferred (mem_wready=1) while in_en carries 0x30/0x3333. Expect memory receives 0x1111, then a second write of 0x3333, with count going 1 then 1 then 0.
- Overflow: buffer full, mem_wready=0, in_en for a new addr 0x60. Expect the eviction dropped, overflow=1 the next cycle and held, count=4, and lk_addr=0x60 gives lk_hit=0. Then assert rst_n=0 and expect overflow=0, count=0, mem_wen=0.
